// File: rtl/elelock_pkg.sv
// Shared types and helpers for the N-digit ten-key lock.
// Digits are BCD nibbles; keys arrive as a 10-bit one-per-key vector.
package elelock_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    PROGRAM  = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  function automatic logic is_onehot10(input logic [9:0] k);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'b000, k[i]};
    end
    return (n == 4'd1);
  endfunction

  function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [9:0] k);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) d = DIGIT_W'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/elelock_keyin.sv
// Ten-key front end: flags a fresh single-key press and encodes it to BCD.
// A press counts only when the previous sample was all-released.
module elelock_keyin
  import elelock_pkg::*;
(
  input  logic               ck,
  input  logic               reset_n,
  input  logic [9:0]         tenkey,
  output logic               key_valid,
  output logic [DIGIT_W-1:0] key_digit
);

  logic [9:0] tk_q;

  always_ff @(posedge ck) begin
    if (!reset_n) tk_q <= '0;
    else          tk_q <= tenkey;
  end

  assign key_valid = is_onehot10(tenkey) && (tk_q == '0);
  assign key_digit = onehot_to_bcd(tenkey);

endmodule

// File: rtl/elelock_multi.sv
// N-digit electronic lock with failed-attempt lockout and in-field
// reprogramming of the code while the bolt is retracted.
module elelock_multi
  import elelock_pkg::*;
#(
  parameter int          DIGITS       = 4,
  parameter logic [31:0] DEFAULT_CODE = 32'h0000_6494,
  parameter int          MAX_FAIL     = 3,
  parameter int          LOCKOUT_CYC  = 64
) (
  input  logic       ck,
  input  logic       reset_n,
  input  logic [9:0] tenkey,
  input  logic       close,
  input  logic       prog,
  output logic       lock,
  output logic       lockout,
  output logic       prog_busy,
  output logic [3:0] digit_cnt
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int BUF_W  = (DIGITS - 1) * DIGIT_W;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int LO_W   = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);
  localparam logic [LO_W-1:0]   LO_LOAD  = LO_W'(LOCKOUT_CYC - 1);
  localparam logic [3:0]        LAST_IDX = 4'(DIGITS - 1);

  state_t              state;
  logic [BUF_W-1:0]    entry_buf;
  logic [CODE_W-1:0]   code;
  logic [CODE_W-1:0]   entered;
  logic [FAIL_W-1:0]   fail_cnt;
  logic [FAIL_W-1:0]   fail_next;
  logic [LO_W-1:0]     lo_cnt;
  logic                key_valid;
  logic [DIGIT_W-1:0]  key_digit;
  logic                last_digit;

  elelock_keyin u_keyin (
    .ck        (ck),
    .reset_n   (reset_n),
    .tenkey    (tenkey),
    .key_valid (key_valid),
    .key_digit (key_digit)
  );

  // The completing digit is compared straight from the key path, so only
  // DIGITS-1 earlier digits ever need to be held.
  assign entered    = {entry_buf, key_digit};
  assign last_digit = key_valid && (digit_cnt == LAST_IDX);
  assign fail_next  = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;

  always_ff @(posedge ck) begin
    if (!reset_n) begin
      state     <= LOCKED;
      lock      <= 1'b1;
      lockout   <= 1'b0;
      prog_busy <= 1'b0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      lo_cnt    <= '0;
      code      <= DEFAULT_CODE[CODE_W-1:0];
      entry_buf <= '0;
    end else begin
      case (state)
        LOCKED: begin
          if (last_digit) begin
            digit_cnt <= '0;
            entry_buf <= '0;
            if (entered == code) begin
              state    <= UNLOCKED;
              lock     <= 1'b0;
              fail_cnt <= '0;
            end else begin
              fail_cnt <= fail_next;
              if (fail_next == FAIL_MAX) begin
                state   <= LOCKOUT;
                lockout <= 1'b1;
                lo_cnt  <= LO_LOAD;
              end
            end
          end else if (key_valid) begin
            entry_buf <= entered[BUF_W-1:0];
            digit_cnt <= digit_cnt + 4'd1;
          end
        end

        UNLOCKED: begin
          if (close) begin
            state     <= LOCKED;
            lock      <= 1'b1;
            digit_cnt <= '0;
            entry_buf <= '0;
          end else if (prog) begin
            state     <= PROGRAM;
            prog_busy <= 1'b1;
            digit_cnt <= '0;
            entry_buf <= '0;
          end
        end

        // Abort on close keeps the previous code untouched.
        PROGRAM: begin
          if (close) begin
            state     <= LOCKED;
            lock      <= 1'b1;
            prog_busy <= 1'b0;
            digit_cnt <= '0;
            entry_buf <= '0;
          end else if (last_digit) begin
            state     <= UNLOCKED;
            code      <= entered;
            prog_busy <= 1'b0;
            digit_cnt <= '0;
            entry_buf <= '0;
          end else if (key_valid) begin
            entry_buf <= entered[BUF_W-1:0];
            digit_cnt <= digit_cnt + 4'd1;
          end
        end

        LOCKOUT: begin
          if (lo_cnt == '0) begin
            state     <= LOCKED;
            lockout   <= 1'b0;
            fail_cnt  <= '0;
            digit_cnt <= '0;
            entry_buf <= '0;
          end else begin
            lo_cnt <= lo_cnt - 1'b1;
          end
        end

        default: begin
          state <= LOCKED;
          lock  <= 1'b1;
        end
      endcase
    end
  end

endmodule
